// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   In-order dual-issue scheduler between the decoder and the even/odd SPU
//   execution pipes. It buffers one decoded pair and tracks per-register
//   result latency in a 128-entry scoreboard. Each cycle it issues zero, one
//   or two instructions, one per pipe, and fills unused slots with nop/lnop.
// Ports:
//   clk, rst (sync, active-high), flush (branch flush)
//   pair_valid / pair_ready           : decoder handshake (pair_ready comb.)
//   instrN_word/type/dst/wr/lat       : instruction word, pipe, destination
//   instrN_ra/rb/rc, instrN_src_en    : source registers and use mask
//   issue_{even,odd}_{valid,instr}    : registered issue slots
//   stall_count                       : saturating stall-cycle counter
module dual_issue_scheduler #(
    parameter int LAT_W       = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   pair_valid,
    output logic                   pair_ready,
    input  logic [31:0]            instr1_word,
    input  logic [31:0]            instr2_word,
    input  logic                   instr1_type,
    input  logic                   instr2_type,
    input  logic [6:0]             instr1_dst,
    input  logic [6:0]             instr2_dst,
    input  logic                   instr1_wr,
    input  logic                   instr2_wr,
    input  logic [LAT_W-1:0]       instr1_lat,
    input  logic [LAT_W-1:0]       instr2_lat,
    input  logic [6:0]             instr1_ra,
    input  logic [6:0]             instr1_rb,
    input  logic [6:0]             instr1_rc,
    input  logic [6:0]             instr2_ra,
    input  logic [6:0]             instr2_rb,
    input  logic [6:0]             instr2_rc,
    input  logic [2:0]             instr1_src_en,
    input  logic [2:0]             instr2_src_en,
    output logic                   issue_even_valid,
    output logic                   issue_odd_valid,
    output logic [31:0]            issue_even_instr,
    output logic [31:0]            issue_odd_instr,
    output logic [STALL_CNT_W-1:0] stall_count
);
    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] BOTH   = 2'd1;
    localparam logic [1:0] SECOND = 2'd2;

    localparam logic [31:0] NOP  = 32'h4020_0000;
    localparam logic [31:0] LNOP = 32'h0020_0000;

    logic [1:0] state;

    // Buffered pair
    logic [31:0]      w1, w2;
    logic             t1, t2, wr1, wr2;
    logic [6:0]       d1, d2, ra1, rb1, rc1, ra2, rb2, rc2;
    logic [LAT_W-1:0] l1, l2;
    logic [2:0]       en1, en2;

    logic [LAT_W-1:0] sb [128];

    logic ready1, ready2, raw, waw, issue1, issue2, head_issue, drain, hs, stall_inc;

    always_comb begin
        ready1 = (!en1[0] || sb[ra1] == '0) && (!en1[1] || sb[rb1] == '0) &&
                 (!en1[2] || sb[rc1] == '0) && (!wr1 || sb[d1] == '0);
        ready2 = (!en2[0] || sb[ra2] == '0) && (!en2[1] || sb[rb2] == '0) &&
                 (!en2[2] || sb[rc2] == '0) && (!wr2 || sb[d2] == '0);
        raw    = wr1 && ((en2[0] && ra2 == d1) || (en2[1] && rb2 == d1) ||
                         (en2[2] && rc2 == d1));
        waw    = wr1 && wr2 && (d1 == d2);
        issue1 = !flush && state == BOTH && ready1;
        issue2 = !flush && ((state == BOTH && issue1 && t1 != t2 && ready2 && !raw && !waw) ||
                            (state == SECOND && ready2));
        // The head is instr1 while both are buffered, instr2 afterwards.
        head_issue = (state == BOTH) ? issue1 : issue2;
        drain      = state == EMPTY || (state == BOTH && issue1 && issue2) ||
                     (state == SECOND && issue2);
        pair_ready = !rst && !flush && drain;
        hs         = pair_valid && pair_ready;
        stall_inc  = !flush && state != EMPTY && !head_issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else if (hs) begin
            state <= BOTH;
        end else if (state == BOTH && issue1) begin
            state <= issue2 ? EMPTY : SECOND;
        end else if (state == SECOND && issue2) begin
            state <= EMPTY;
        end
    end

    // Payload needs no reset: it is only observed while state says it is valid.
    always_ff @(posedge clk) begin
        if (hs) begin
            w1  <= instr1_word;  w2  <= instr2_word;
            t1  <= instr1_type;  t2  <= instr2_type;
            d1  <= instr1_dst;   d2  <= instr2_dst;
            wr1 <= instr1_wr;    wr2 <= instr2_wr;
            l1  <= instr1_lat;   l2  <= instr2_lat;
            ra1 <= instr1_ra;    rb1 <= instr1_rb;    rc1 <= instr1_rc;
            ra2 <= instr2_ra;    rb2 <= instr2_rb;    rc2 <= instr2_rc;
            en1 <= instr1_src_en;
            en2 <= instr2_src_en;
        end
    end

    // Co-issue needs differing types, so at most one source targets each pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_even_valid <= 1'b0;
            issue_odd_valid  <= 1'b0;
            issue_even_instr <= NOP;
            issue_odd_instr  <= LNOP;
        end else begin
            issue_even_valid <= (issue1 && !t1) || (issue2 && !t2);
            issue_odd_valid  <= (issue1 && t1) || (issue2 && t2);
            issue_even_instr <= (issue1 && !t1) ? w1 : (issue2 && !t2) ? w2 : NOP;
            issue_odd_instr  <= (issue1 && t1)  ? w1 : (issue2 && t2)  ? w2 : LNOP;
        end
    end

    // A set beats the decrement; a co-issued pair never targets one register
    // because WAW pairs are split.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 128; r++) begin
            if (rst)
                sb[r] <= '0;
            else if (issue1 && wr1 && d1 == 7'(r))
                sb[r] <= l1;
            else if (issue2 && wr2 && d2 == 7'(r))
                sb[r] <= l2;
            else if (sb[r] != '0)
                sb[r] <= sb[r] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (stall_inc && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end
endmodule

// File: tb/tb_dual_issue_scheduler.sv
module tb_dual_issue_scheduler;
    logic        clk = 1'b0;
    logic        rst, flush, pair_valid, pair_ready;
    logic [31:0] instr1_word, instr2_word;
    logic        instr1_type, instr2_type, instr1_wr, instr2_wr;
    logic [6:0]  instr1_dst, instr2_dst;
    logic [3:0]  instr1_lat, instr2_lat;
    logic [6:0]  instr1_ra, instr1_rb, instr1_rc, instr2_ra, instr2_rb, instr2_rc;
    logic [2:0]  instr1_src_en, instr2_src_en;
    logic        issue_even_valid, issue_odd_valid;
    logic [31:0] issue_even_instr, issue_odd_instr;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] NOP  = 32'h4020_0000;
    localparam logic [31:0] LNOP = 32'h0020_0000;

    dual_issue_scheduler #(.LAT_W(4), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .pair_valid(pair_valid), .pair_ready(pair_ready),
        .instr1_word(instr1_word), .instr2_word(instr2_word),
        .instr1_type(instr1_type), .instr2_type(instr2_type),
        .instr1_dst(instr1_dst), .instr2_dst(instr2_dst),
        .instr1_wr(instr1_wr), .instr2_wr(instr2_wr),
        .instr1_lat(instr1_lat), .instr2_lat(instr2_lat),
        .instr1_ra(instr1_ra), .instr1_rb(instr1_rb), .instr1_rc(instr1_rc),
        .instr2_ra(instr2_ra), .instr2_rb(instr2_rb), .instr2_rc(instr2_rc),
        .instr1_src_en(instr1_src_en), .instr2_src_en(instr2_src_en),
        .issue_even_valid(issue_even_valid), .issue_odd_valid(issue_odd_valid),
        .issue_even_instr(issue_even_instr), .issue_odd_instr(issue_odd_instr),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check both issue slots at once.
    task automatic chk_out(input string tag, input logic ev, input logic [31:0] ei,
                           input logic ov, input logic [31:0] oi);
        chk({tag, ".even_v"}, {31'd0, issue_even_valid}, {31'd0, ev});
        chk({tag, ".even_i"}, issue_even_instr, ei);
        chk({tag, ".odd_v"},  {31'd0, issue_odd_valid}, {31'd0, ov});
        chk({tag, ".odd_i"},  issue_odd_instr, oi);
    endtask

    task automatic set1(input logic [31:0] w, input logic t, input logic [6:0] d,
                        input logic wr, input logic [3:0] lat, input logic [6:0] ra,
                        input logic [2:0] en);
        instr1_word = w; instr1_type = t; instr1_dst = d; instr1_wr = wr;
        instr1_lat = lat; instr1_ra = ra; instr1_rb = 7'd0; instr1_rc = 7'd0;
        instr1_src_en = en;
    endtask

    task automatic set2(input logic [31:0] w, input logic t, input logic [6:0] d,
                        input logic wr, input logic [3:0] lat, input logic [6:0] ra,
                        input logic [2:0] en);
        instr2_word = w; instr2_type = t; instr2_dst = d; instr2_wr = wr;
        instr2_lat = lat; instr2_ra = ra; instr2_rb = 7'd0; instr2_rc = 7'd0;
        instr2_src_en = en;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pair_valid = 1'b0;
        set1(32'h0, 1'b0, 7'd0, 1'b0, 4'd0, 7'd0, 3'b000);
        set2(32'h0, 1'b0, 7'd0, 1'b0, 4'd0, 7'd0, 3'b000);
        tick(); tick();
        chk("rst.ready", {31'd0, pair_ready}, 32'd0);
        chk_out("rst", 1'b0, NOP, 1'b0, LNOP);
        chk("rst.stall", {16'd0, stall_count}, 32'd0);
        rst = 1'b0;
        #1 chk("idle.ready", {31'd0, pair_ready}, 32'd1);

        // Hazard-free pair
        set1(32'hA000_0001, 1'b0, 7'd5, 1'b1, 4'd2, 7'd1, 3'b011);
        set2(32'hB000_0001, 1'b1, 7'd6, 1'b1, 4'd1, 7'd7, 3'b001);
        pair_valid = 1'b1;
        tick();
        pair_valid = 1'b0;
        #1 chk("hf.ready", {31'd0, pair_ready}, 32'd1);
        tick();
        chk_out("hf", 1'b1, 32'hA000_0001, 1'b1, 32'hB000_0001);
        chk("hf.stall", {16'd0, stall_count}, 32'd0);

        // Structural split: two even-pipe instructions
        set1(32'hE000_0001, 1'b0, 7'd20, 1'b1, 4'd1, 7'd0, 3'b000);
        set2(32'hE000_0002, 1'b0, 7'd21, 1'b1, 4'd1, 7'd0, 3'b000);
        pair_valid = 1'b1;
        tick();
        pair_valid = 1'b0;
        #1 chk("split.ready0", {31'd0, pair_ready}, 32'd0);
        tick();
        chk_out("split1", 1'b1, 32'hE000_0001, 1'b0, LNOP);
        chk("split.ready1", {31'd0, pair_ready}, 32'd1);
        tick();
        chk_out("split2", 1'b1, 32'hE000_0002, 1'b0, LNOP);
        chk("split.stall", {16'd0, stall_count}, 32'd0);

        // Intra-pair RAW on r10, latency 4
        set1(32'hC000_0001, 1'b0, 7'd10, 1'b1, 4'd4, 7'd0, 3'b000);
        set2(32'hC000_0002, 1'b1, 7'd11, 1'b1, 4'd1, 7'd10, 3'b001);
        pair_valid = 1'b1;
        tick();
        pair_valid = 1'b0;
        #1 chk("raw.ready0", {31'd0, pair_ready}, 32'd0);
        tick();
        chk_out("raw.i1", 1'b1, 32'hC000_0001, 1'b0, LNOP);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("raw.wait", 1'b0, NOP, 1'b0, LNOP);
        end
        chk("raw.stall", {16'd0, stall_count}, 32'd4);
        chk("raw.ready1", {31'd0, pair_ready}, 32'd1);
        tick();
        chk_out("raw.i2", 1'b0, NOP, 1'b1, 32'hC000_0002);
        chk("raw.stall2", {16'd0, stall_count}, 32'd4);

        // Cross-pair dependency: lat-6 write to r3, then a pair reading r3
        set1(32'hD000_0001, 1'b0, 7'd3, 1'b1, 4'd6, 7'd0, 3'b000);
        set2(32'hD000_0002, 1'b1, 7'd30, 1'b1, 4'd1, 7'd0, 3'b000);
        pair_valid = 1'b1;
        tick();
        set1(32'hD100_0001, 1'b0, 7'd31, 1'b1, 4'd1, 7'd3, 3'b001);
        set2(32'hD100_0002, 1'b1, 7'd32, 1'b0, 4'd0, 7'd0, 3'b000);
        #1 chk("xp.ready", {31'd0, pair_ready}, 32'd1);
        tick();
        pair_valid = 1'b0;
        chk_out("xp.prod", 1'b1, 32'hD000_0001, 1'b1, 32'hD000_0002);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_out("xp.wait", 1'b0, NOP, 1'b0, LNOP);
        end
        tick();
        chk_out("xp.cons", 1'b1, 32'hD100_0001, 1'b1, 32'hD100_0002);
        chk("xp.stall", {16'd0, stall_count}, 32'd10);

        // Flush while instr2 is pending
        set1(32'hF000_0001, 1'b0, 7'd12, 1'b1, 4'd3, 7'd0, 3'b000);
        set2(32'hF000_0002, 1'b1, 7'd13, 1'b1, 4'd1, 7'd12, 3'b001);
        pair_valid = 1'b1;
        tick();
        pair_valid = 1'b0;
        tick();
        chk_out("fl.i1", 1'b1, 32'hF000_0001, 1'b0, LNOP);
        flush = 1'b1;
        #1 chk("fl.ready0", {31'd0, pair_ready}, 32'd0);
        tick();
        flush = 1'b0;
        chk_out("fl.out", 1'b0, NOP, 1'b0, LNOP);
        #1 chk("fl.ready1", {31'd0, pair_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("fl.dropped", 1'b0, NOP, 1'b0, LNOP);
        end
        chk("fl.stall", {16'd0, stall_count}, 32'd10);

        // Reset during a scoreboard wait (r40, latency 9)
        set1(32'h6000_0001, 1'b0, 7'd40, 1'b1, 4'd9, 7'd0, 3'b000);
        set2(32'h6000_0002, 1'b0, 7'd41, 1'b1, 4'd1, 7'd40, 3'b001);
        pair_valid = 1'b1;
        tick();
        pair_valid = 1'b0;
        tick();
        chk_out("rs.i1", 1'b1, 32'h6000_0001, 1'b0, LNOP);
        tick(); tick();
        chk("rs.stall", {16'd0, stall_count}, 32'd12);
        rst = 1'b1;
        #1 chk("rs.ready0", {31'd0, pair_ready}, 32'd0);
        tick();
        rst = 1'b0;
        chk_out("rs.out", 1'b0, NOP, 1'b0, LNOP);
        chk("rs.stall0", {16'd0, stall_count}, 32'd0);
        set1(32'h7000_0001, 1'b0, 7'd42, 1'b1, 4'd1, 7'd40, 3'b001);
        set2(32'h7000_0002, 1'b1, 7'd43, 1'b1, 4'd1, 7'd41, 3'b001);
        pair_valid = 1'b1;
        #1 chk("rs.ready1", {31'd0, pair_ready}, 32'd1);
        tick();
        pair_valid = 1'b0;
        tick();
        chk_out("rs.dep", 1'b1, 32'h7000_0001, 1'b1, 32'h7000_0002);

        // Latency 0 never blocks; instr1 routed to the odd pipe
        set1(32'h8000_0001, 1'b0, 7'd50, 1'b1, 4'd0, 7'd0, 3'b000);
        set2(32'h8000_0002, 1'b1, 7'd51, 1'b0, 4'd0, 7'd0, 3'b000);
        pair_valid = 1'b1;
        tick();
        set1(32'h9000_0001, 1'b1, 7'd52, 1'b0, 4'd0, 7'd50, 3'b001);
        set2(32'h9000_0002, 1'b0, 7'd53, 1'b0, 4'd0, 7'd0, 3'b000);
        tick();
        pair_valid = 1'b0;
        chk_out("l0.prod", 1'b1, 32'h8000_0001, 1'b1, 32'h8000_0002);
        tick();
        chk_out("l0.cons", 1'b1, 32'h9000_0002, 1'b1, 32'h9000_0001);
        chk("l0.stall", {16'd0, stall_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
